// File: rtl/result_collector.sv
// Collects one frame of DIM*DIM complex accumulator results, tags each with its
// row-major matrix position and buffers them in a small FIFO for a ready/valid consumer.
module result_collector #(
  parameter int unsigned ANCHO_PALABRA = 32,
  parameter int unsigned DIM           = 32,
  parameter int unsigned FIFO_DEPTH    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       flag,
  input  logic [ANCHO_PALABRA-1:0]   accR,
  input  logic [ANCHO_PALABRA-1:0]   accI,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [ANCHO_PALABRA-1:0]   out_real,
  output logic [ANCHO_PALABRA-1:0]   out_imag,
  output logic [$clog2(DIM)-1:0]     out_row,
  output logic [$clog2(DIM)-1:0]     out_col,
  output logic                       busy,
  output logic                       done,
  output logic                       overflow
);

  localparam int unsigned RW = $clog2(DIM);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = 2 * RW + 2 * ANCHO_PALABRA;

  localparam logic [RW-1:0] LAST_POS = RW'(DIM - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] DRAIN   = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          flag_q;
  logic [RW-1:0] row_q, col_q;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          overflow_q;

  logic [EW-1:0] mem [FIFO_DEPTH];

  logic                     capture, full, empty, pop, push, drop, restart, last_pos;
  logic [RW-1:0]            head_row, head_col;
  logic [ANCHO_PALABRA-1:0] head_re, head_im;

  assign capture  = (state_q == COLLECT) && flag && !flag_q;
  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign pop      = !empty && out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push     = capture && (!full || pop);
  assign drop     = capture && full && !pop;
  assign restart  = start && ((state_q == IDLE) || (state_q == DONE));
  assign last_pos = (row_q == LAST_POS) && (col_q == LAST_POS);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = COLLECT;
      COLLECT:    if (capture && last_pos) state_d = DRAIN;
      DRAIN:      if (empty) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      flag_q     <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      flag_q  <= flag;
      if (restart) begin
        row_q      <= '0;
        col_q      <= '0;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        count_q    <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        case ({push, pop})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
        // Position advances on every capture, including dropped ones.
        if (capture) begin
          if (col_q == LAST_POS) begin
            col_q <= '0;
            row_q <= (row_q == LAST_POS) ? '0 : row_q + RW'(1);
          end else begin
            col_q <= col_q + RW'(1);
          end
        end
        if (drop) overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {row_q, col_q, accR, accI};
  end

  assign {head_row, head_col, head_re, head_im} = mem[rd_ptr_q];

  // Data outputs are gated so reset and empty states read as zero.
  assign out_valid = !empty;
  assign out_real  = out_valid ? head_re  : '0;
  assign out_imag  = out_valid ? head_im  : '0;
  assign out_row   = out_valid ? head_row : '0;
  assign out_col   = out_valid ? head_col : '0;
  assign busy      = (state_q == COLLECT) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_result_collector.sv
// Bench for result_collector: a DIM=4 instance checked every cycle against a queue model,
// and a DIM=2 instance sharing the same stimulus, checked on directed frame points.
module tb_result_collector;

  localparam int D4    = 4;
  localparam int DEPTH = 8;
  localparam int M_IDLE = 0, M_COLLECT = 1, M_DRAIN = 2, M_DONE = 3;

  logic        clk = 1'b0;
  logic        rst, start, flag, out_ready;
  logic [31:0] accR, accI;

  logic        v4, busy4, done4, ovf4;
  logic [31:0] re4, im4;
  logic [1:0]  row4, col4;
  logic        v2, busy2, done2, ovf2;
  logic [31:0] re2, im2;
  logic [0:0]  row2, col2;

  always #5 clk = ~clk;

  result_collector #(.ANCHO_PALABRA(32), .DIM(4), .FIFO_DEPTH(8)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .flag(flag), .accR(accR), .accI(accI),
    .out_ready(out_ready), .out_valid(v4), .out_real(re4), .out_imag(im4),
    .out_row(row4), .out_col(col4), .busy(busy4), .done(done4), .overflow(ovf4)
  );

  result_collector #(.ANCHO_PALABRA(32), .DIM(2), .FIFO_DEPTH(8)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .flag(flag), .accR(accR), .accI(accI),
    .out_ready(out_ready), .out_valid(v2), .out_real(re2), .out_imag(im2),
    .out_row(row2), .out_col(col2), .busy(busy2), .done(done2), .overflow(ovf2)
  );

  typedef struct {
    int unsigned pos;
    logic [31:0] re;
    logic [31:0] im;
  } ent_t;

  ent_t        mq[$];
  int          mst;
  int unsigned midx;
  logic        movf;
  logic        mflag;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mst   = M_IDLE;
    midx  = 0;
    movf  = 1'b0;
    mflag = 1'b0;
  endtask

  // Frame rules applied once per rising edge, using the inputs seen at that edge.
  task automatic model_step();
    bit   pop, cap, full;
    ent_t e;
    if (rst) begin
      model_reset();
      return;
    end
    pop   = (mq.size() != 0) && out_ready;
    cap   = (mst == M_COLLECT) && flag && !mflag;
    full  = (mq.size() == DEPTH);
    mflag = flag;
    case (mst)
      M_IDLE, M_DONE: begin
        if (start) begin
          mst = M_COLLECT;
          mq.delete();
          midx = 0;
          movf = 1'b0;
        end
      end
      M_COLLECT: begin
        if (pop) void'(mq.pop_front());
        if (cap) begin
          if (!full || pop) begin
            e.pos = midx;
            e.re  = accR;
            e.im  = accI;
            mq.push_back(e);
          end else begin
            movf = 1'b1;
          end
          if (midx == D4 * D4 - 1) mst = M_DRAIN;
          midx++;
        end
      end
      default: begin
        if (mq.size() == 0) mst = M_DONE;
        else if (pop) void'(mq.pop_front());
      end
    endcase
  endtask

  task automatic check_model();
    chk("dut4_valid", 64'(v4), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("dut4_real", 64'(re4), 64'(mq[0].re));
      chk("dut4_imag", 64'(im4), 64'(mq[0].im));
      chk("dut4_row", 64'(row4), 64'(mq[0].pos / D4));
      chk("dut4_col", 64'(col4), 64'(mq[0].pos % D4));
    end
    chk("dut4_busy", 64'(busy4), 64'((mst == M_COLLECT) || (mst == M_DRAIN)));
    chk("dut4_done", 64'(done4), 64'(mst == M_DONE));
    chk("dut4_overflow", 64'(ovf4), 64'(movf));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic pulse();
    flag = 1'b1;
    accR = $urandom;
    accI = $urandom;
    cycle();
    flag = 1'b0;
    cycle();
  endtask

  task automatic random_until_done(input string tag);
    int n = 0;
    while (mst != M_DONE && n < 2000) begin
      flag      = 1'($urandom_range(0, 1));
      accR      = $urandom;
      accI      = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
      n++;
    end
    flag = 1'b0;
    chk(tag, 64'(done4), 64'(1));
  endtask

  logic [31:0] v0;
  int          n;

  initial begin
    rst = 1'b0; start = 1'b0; flag = 1'b0; out_ready = 1'b0; accR = '0; accI = '0;
    model_reset();
    #1 rst = 1'b1;
    #1;
    check_model();
    chk("rst_real4", 64'(re4), 64'(0));
    chk("rst_row4", 64'(row4), 64'(0));
    chk("rst_valid2", 64'(v2), 64'(0));
    chk("rst_imag2", 64'(im2), 64'(0));
    chk("rst_busy2", 64'(busy2), 64'(0));
    chk("rst_done2", 64'(done2), 64'(0));
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // DIM=2 frame: four pulses, each visible one cycle after its edge.
    out_ready = 1'b1;
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("f1_busy2", 64'(busy2), 64'(1));
    for (int k = 1; k <= 4; k++) begin
      flag = 1'b1;
      accR = 32'(k << 16);
      accI = $urandom;
      cycle();
      chk("f1_valid2", 64'(v2), 64'(1));
      chk("f1_real2", 64'(re2), 64'(k << 16));
      chk("f1_imag2", 64'(im2), 64'(accI));
      chk("f1_row2", 64'(row2), 64'((k - 1) / 2));
      chk("f1_col2", 64'(col2), 64'((k - 1) % 2));
      flag = 1'b0;
      cycle();
    end
    cycle();
    chk("f1_done2", 64'(done2), 64'(1));
    chk("f1_ovf2", 64'(ovf2), 64'(0));

    // Flag held high for five cycles: only the rising-edge value is captured.
    flag = 1'b1;
    accR = $urandom;
    v0   = accR;
    cycle();
    chk("hold_real4", 64'(re4), 64'(v0));
    for (int k = 0; k < 4; k++) begin
      accR = $urandom;
      cycle();
    end
    flag = 1'b0;
    cycle();
    chk("hold_single4", 64'(v4), 64'(0));

    random_until_done("f1_done4");

    // Restart from DONE, then overflow with the consumer stalled.
    out_ready = 1'b0;
    flag = 1'b0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("f2_ovf_clr4", 64'(ovf4), 64'(0));
    chk("f2_busy4", 64'(busy4), 64'(1));
    chk("f2_busy2", 64'(busy2), 64'(1));
    chk("f2_done2", 64'(done2), 64'(0));
    for (int k = 0; k < 9; k++) pulse();
    chk("f2_ovf4", 64'(ovf4), 64'(1));
    chk("f2_head_row4", 64'(row4), 64'(0));
    chk("f2_head_col4", 64'(col4), 64'(0));
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) cycle();
    chk("f2_empty4", 64'(v4), 64'(0));
    flag = 1'b1;
    accR = $urandom;
    cycle();
    chk("f2_skip_row4", 64'(row4), 64'(2));
    chk("f2_skip_col4", 64'(col4), 64'(1));
    flag = 1'b0;
    cycle();

    // Asynchronous reset three captures into a fresh frame.
    out_ready = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_model();
    cycle();
    rst = 1'b0;
    cycle();
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int k = 0; k < 3; k++) pulse();
    chk("r_valid_before4", 64'(v4), 64'(1));
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("r_valid4", 64'(v4), 64'(0));
    chk("r_busy4", 64'(busy4), 64'(0));
    chk("r_real4", 64'(re4), 64'(0));
    chk("r_valid2", 64'(v2), 64'(0));
    cycle();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      pulse();
      chk("r_ignored4", 64'(v4), 64'(0));
      chk("r_idle4", 64'(busy4), 64'(0));
    end

    // Full FIFO: a capture coinciding with a pop is accepted.
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int k = 0; k < 8; k++) pulse();
    chk("full_ovf4", 64'(ovf4), 64'(0));
    flag = 1'b1;
    out_ready = 1'b1;
    accR = $urandom;
    cycle();
    flag = 1'b0;
    chk("sim_ovf4", 64'(ovf4), 64'(0));
    chk("sim_row4", 64'(row4), 64'(0));
    chk("sim_col4", 64'(col4), 64'(1));
    n = 0;
    while (v4 && n < 20) begin
      n++;
      cycle();
    end
    chk("sim_occupancy4", 64'(n), 64'(8));

    random_until_done("f4_done4");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
